// File: rtl/sdpram_pkg.sv
// Shared constants and parameter legality check for the sdpram_sclk RAM.
package sdpram_pkg;

    // Legal values of the ENABLE_BYPASS string parameter.
    localparam string BYPASS_TRUE  = "TRUE";
    localparam string BYPASS_FALSE = "FALSE";

    // Returns 1 when the width parameters are positive and exactly one of
    // the recognised bypass strings was selected.
    function automatic bit sdpram_params_ok(
        input int aw,
        input int dw,
        input bit byp_is_true,
        input bit byp_is_false
    );
        return (aw > 0) && (dw > 0) && (byp_is_true || byp_is_false);
    endfunction

endpackage

// File: rtl/sdpram_bypass.sv
// Write-to-read collision bypass for sdpram_sclk.
// Detects a same-edge write to the address being read, remembers that fact
// and the written word, and substitutes that word for the RAM output on the
// following cycle. Keeping this outside the memory array lets the RAM itself
// stay a plain read-first block RAM.
import sdpram_pkg::*;

module sdpram_bypass #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_re,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [DATA_WIDTH-1:0] i_ram_q,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic                  w_hit;
    logic                  r_byp_flag;
    logic [DATA_WIDTH-1:0] r_byp_data;

    assign w_hit = i_we && (i_waddr == i_raddr);

    // Flag and data only move on a read capture so dout holds while re=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byp_flag <= 1'b0;
            r_byp_data <= '0;
        end else if (i_re) begin
            r_byp_flag <= w_hit;
            if (w_hit) begin
                r_byp_data <= i_din;
            end
        end
    end

    // Forwarded write data wins over the (stale) RAM word after a collision.
    always_comb begin
        o_dout = r_byp_flag ? r_byp_data : i_ram_q;
    end

endmodule

// File: rtl/sdpram_sclk.sv
// Single-clock simple dual-port RAM: one write port, one registered read
// port with 1-cycle latency. ENABLE_BYPASS="TRUE" adds write-first
// forwarding on address collision; "FALSE" keeps read-first behaviour.
// Optional macro SDPRAM_READ_ENABLE_EN adds a read-enable input 're' that
// gates the read register and bypass capture; without it reads happen
// every cycle.
// Memory is never reset so the array maps onto block RAM; the reset only
// clears the output-side registers.
import sdpram_pkg::*;

module sdpram_sclk #(
    parameter int    ADDR_WIDTH    = 8,
    parameter int    DATA_WIDTH    = 32,
    parameter string ENABLE_BYPASS = "TRUE"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] raddr,
`ifdef SDPRAM_READ_ENABLE_EN
    input  logic                  re,
`endif
    output logic [DATA_WIDTH-1:0] dout,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din
);

    localparam int  DEPTH    = 1 << ADDR_WIDTH;
    localparam bit  BYP_TRUE = (ENABLE_BYPASS == BYPASS_TRUE);
    localparam bit  BYP_FALS = (ENABLE_BYPASS == BYPASS_FALSE);

    // Elaboration-time sanity check; simulators report it, synthesis ignores it.
    if (!sdpram_params_ok(ADDR_WIDTH, DATA_WIDTH, BYP_TRUE, BYP_FALS)) begin : g_param_err
        $error("sdpram_sclk: illegal parameters (ADDR_WIDTH and DATA_WIDTH must be >0, ENABLE_BYPASS must be \"TRUE\" or \"FALSE\")");
    end

    logic                  w_re;
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

`ifdef SDPRAM_READ_ENABLE_EN
    assign w_re = re;
`else
    assign w_re = 1'b1;
`endif

    // Write port; deliberately unaffected by reset so a write on a reset
    // edge still lands and the array stays inferable as block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= din;
        end
    end

    // Registered read-first capture; holds when reads are disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    if (BYP_TRUE) begin : g_bypass
        sdpram_bypass #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bypass (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_re    (w_re),
            .i_we    (we),
            .i_waddr (waddr),
            .i_raddr (raddr),
            .i_din   (din),
            .i_ram_q (r_rdata),
            .o_dout  (dout)
        );
    end else begin : g_no_bypass
        assign dout = r_rdata;
    end

endmodule

// File: tb/tb_sdpram_sclk.sv
// Self-checking bench for sdpram_sclk: one bypass-enabled and one
// read-first instance share all inputs; a reference memory model produces
// the expected word for each instance and a scoreboard queue carries it to
// the cycle where dout is sampled.
module tb_sdpram_sclk;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we;
    logic          re;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout_t;
    logic [DW-1:0] dout_f;

    always #5 clk = ~clk;

    sdpram_sclk #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ENABLE_BYPASS("TRUE")) u_dut_t (
        .clk   (clk),
        .rst_n (rst_n),
        .raddr (raddr),
`ifdef SDPRAM_READ_ENABLE_EN
        .re    (re),
`endif
        .dout  (dout_t),
        .waddr (waddr),
        .we    (we),
        .din   (din)
    );

    sdpram_sclk #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ENABLE_BYPASS("FALSE")) u_dut_f (
        .clk   (clk),
        .rst_n (rst_n),
        .raddr (raddr),
`ifdef SDPRAM_READ_ENABLE_EN
        .re    (re),
`endif
        .dout  (dout_f),
        .waddr (waddr),
        .we    (we),
        .din   (din)
    );

    typedef struct {
        logic [DW-1:0] t;
        logic [DW-1:0] f;
        string         nm;
    } exp_s;

    exp_s          sb[$];
    logic [DW-1:0] mdl [0:(1<<AW)-1];
    logic [DW-1:0] last_t;
    logic [DW-1:0] last_f;
    int            n_chk  = 0;
    int            n_fail = 0;

    // One clock of stimulus: drive at negedge, predict, sample #1 after posedge.
    task automatic step(input logic rst, input logic w, input logic [AW-1:0] wa,
                        input logic [DW-1:0] d, input logic [AW-1:0] ra,
                        input logic r, input bit chk, input string nm);
        exp_s e;
        logic rr;
        rr = r;
`ifndef SDPRAM_READ_ENABLE_EN
        rr = 1'b1;
`endif
        @(negedge clk);
        rst_n = rst; we = w; waddr = wa; din = d; raddr = ra; re = r;
        if (!rst) begin
            last_t = '0;
            last_f = '0;
        end else if (rr) begin
            last_f = mdl[ra];
            last_t = (w && (wa == ra)) ? d : mdl[ra];
        end
        e.t = last_t; e.f = last_f; e.nm = nm;
        if (chk) sb.push_back(e);
        if (w) mdl[wa] = d;
        @(posedge clk);
        #1;
        if (chk) begin
            e = sb.pop_front();
            n_chk++;
            if (dout_t !== e.t) begin
                n_fail++;
                $display("FAIL %s bypass: dout=%h expected=%h", e.nm, dout_t, e.t);
            end
            n_chk++;
            if (dout_f !== e.f) begin
                n_fail++;
                $display("FAIL %s readfirst: dout=%h expected=%h", e.nm, dout_f, e.f);
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b1, 1'b1, "reset0");
        step(1'b0, 1'b0, 8'd0, 32'd0, 8'd1, 1'b1, 1'b1, "reset1");
    endtask

    task automatic test_basic();
        step(1'b1, 1'b1, 8'd3, 32'hA5A5A5A5, 8'd0, 1'b1, 1'b0, "wr3");
        step(1'b1, 1'b0, 8'd0, 32'd0, 8'd3, 1'b1, 1'b1, "rd3");
        step(1'b1, 1'b0, 8'd0, 32'd0, 8'd3, 1'b1, 1'b1, "rd3_again");
    endtask

    task automatic test_fill_wrap();
        logic [AW-1:0] a;
        for (int i = 0; i < (1 << AW); i++) begin
            a = AW'(i);
            step(1'b1, 1'b1, a, {24'd0, a ^ 8'h55}, 8'd200, 1'b1, 1'b0, "fill");
        end
        for (int i = 0; i <= (1 << AW); i++) begin
            a = AW'(240 + i);
            step(1'b1, 1'b0, 8'd0, 32'd0, a, 1'b1, 1'b1, "fill_rd");
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        for (int i = 0; i < 300; i++) begin
            wa = AW'($urandom_range(0, (1 << AW) - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, (1 << AW) - 1));
            step(1'b1, 1'($urandom_range(0, 1)), wa, $urandom(), ra, 1'b1, 1'b1, "b2b");
        end
    endtask

    task automatic test_collision();
        step(1'b1, 1'b1, 8'd7, 32'h11, 8'd0, 1'b1, 1'b0, "wr7");
        step(1'b1, 1'b1, 8'd7, 32'h22, 8'd7, 1'b1, 1'b1, "collide7");
        step(1'b1, 1'b0, 8'd0, 32'd0, 8'd7, 1'b1, 1'b1, "reread7");
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 8'd9, 32'h99, 8'd7, 1'b1, 1'b1, "midrst");
        step(1'b1, 1'b0, 8'd0, 32'd0, 8'd7, 1'b1, 1'b1, "post_rst7");
        step(1'b1, 1'b0, 8'd0, 32'd0, 8'd9, 1'b1, 1'b1, "rst_write9");
    endtask

`ifdef SDPRAM_READ_ENABLE_EN
    task automatic test_read_enable();
        step(1'b1, 1'b1, 8'd5, 32'h33, 8'd3, 1'b1, 1'b1, "re_rd3");
        step(1'b1, 1'b0, 8'd0, 32'd0, 8'd5, 1'b0, 1'b1, "re0_a");
        step(1'b1, 1'b1, 8'd4, 32'h44, 8'd4, 1'b0, 1'b1, "re0_collide");
        step(1'b1, 1'b0, 8'd0, 32'd0, 8'd9, 1'b0, 1'b1, "re0_b");
        step(1'b1, 1'b0, 8'd0, 32'd0, 8'd5, 1'b1, 1'b1, "re1_rd5");
        step(1'b1, 1'b1, 8'd5, 32'h55, 8'd5, 1'b1, 1'b1, "re1_collide");
    endtask
`endif

    initial begin
        rst_n = 1'b0; we = 1'b0; re = 1'b1;
        raddr = '0; waddr = '0; din = '0;
        last_t = '0; last_f = '0;
        test_reset();
        test_basic();
        test_fill_wrap();
        test_collision();
        test_reset_mid();
        test_back_to_back();
`ifdef SDPRAM_READ_ENABLE_EN
        test_read_enable();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
